// File: rtl/mips_avalon_arbiter.sv
// N-master to 1-slave Avalon-MM arbiter: fixed-priority or round-robin, grant held per transaction.
// Optional watchdog (TOUT state, SLAVEERROR response) enabled by defining MIPS_ARB_TIMEOUT_EN.
module mips_avalon_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_byteenable,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_writedata,
    output logic [NUM_MASTERS-1:0]            m_waitrequest,
    output logic [DATA_W-1:0]                 m_readdata,
    output logic [1:0]                        m_response,
    output logic [ADDR_W-1:0]                 s_address,
    output logic [(DATA_W/8)-1:0]             s_byteenable,
    output logic                              s_read,
    output logic                              s_write,
    output logic [DATA_W-1:0]                 s_writedata,
    input  logic                              s_waitrequest,
    input  logic [DATA_W-1:0]                 s_readdata,
    input  logic [1:0]                        s_response,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
`ifdef MIPS_ARB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TOUT = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]         r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]         r_rr_ptr, w_rr_nxt;
    logic [IDX_W-1:0]         w_win;
    logic                     w_found;
    logic                     r_busy;
    logic [NUM_MASTERS-1:0]   w_req;
    int                       w_idx;
`ifdef MIPS_ARB_TIMEOUT_EN
    logic [TCNT_W-1:0]        r_tcnt, w_tcnt_nxt;
`endif

    logic [ADDR_W-1:0]        w_g_addr;
    logic [BE_W-1:0]          w_g_be;
    logic [DATA_W-1:0]        w_g_wdata;
    logic                     w_g_read;
    logic                     w_g_write;

    assign w_req = m_read | m_write;
    assign grant = r_grant;
    assign busy  = r_busy;

    // Winner search: from index 0 (fixed) or from rr_ptr with wrap (round-robin).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = (ARB_MODE == 1) ? (int'(r_rr_ptr) + k) % NUM_MASTERS : k;
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(w_idx);
            end
        end
    end

    // Select the granted master's request slices.
    always_comb begin
        w_g_addr  = '0;
        w_g_be    = '0;
        w_g_wdata = '0;
        w_g_read  = 1'b0;
        w_g_write = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_gidx == IDX_W'(i)) begin
                w_g_addr  = m_address[i*ADDR_W +: ADDR_W];
                w_g_be    = m_byteenable[i*BE_W +: BE_W];
                w_g_wdata = m_writedata[i*DATA_W +: DATA_W];
                w_g_read  = m_read[i];
                w_g_write = m_write[i];
            end
        end
    end

    // Next-state and slave/master-side outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_rr_nxt      = r_rr_ptr;
`ifdef MIPS_ARB_TIMEOUT_EN
        w_tcnt_nxt    = r_tcnt;
`endif
        m_waitrequest = '1;
        m_readdata    = '0;
        m_response    = '0;
        s_address     = '0;
        s_byteenable  = '0;
        s_writedata   = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = NUM_MASTERS'(1) << w_win;
                    w_gidx_nxt  = w_win;
                    if (ARB_MODE == 1)
                        w_rr_nxt = (int'(w_win) == NUM_MASTERS - 1) ? '0 : w_win + 1'b1;
`ifdef MIPS_ARB_TIMEOUT_EN
                    w_tcnt_nxt  = '0;
`endif
                end
            end
            S_BUSY: begin
                s_address    = w_g_addr;
                s_byteenable = w_g_be;
                s_writedata  = w_g_wdata;
                s_read       = w_g_read;
                // A master raising both strobes is served as a read.
                s_write      = w_g_write & ~w_g_read;
                m_readdata   = s_readdata;
                m_response   = s_response;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (r_gidx == IDX_W'(i)) m_waitrequest[i] = s_waitrequest;
                end
                if (!(w_g_read | w_g_write) || !s_waitrequest) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
`ifdef MIPS_ARB_TIMEOUT_EN
                else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_TOUT;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
`endif
            end
`ifdef MIPS_ARB_TIMEOUT_EN
            S_TOUT: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (r_gidx == IDX_W'(i)) m_waitrequest[i] = 1'b0;
                end
                m_response  = 2'b10;
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_busy   <= 1'b0;
`ifdef MIPS_ARB_TIMEOUT_EN
            r_tcnt   <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_busy   <= (w_state_nxt == S_BUSY);
`ifdef MIPS_ARB_TIMEOUT_EN
            r_tcnt   <= w_tcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter: a 3-master fixed-priority and a 4-master round-robin instance.
module tb_mips_avalon_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NF = 3;
    localparam int NR = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Fixed-priority instance
    logic [NF*AW-1:0] fp_addr;
    logic [NF*BW-1:0] fp_be;
    logic [NF-1:0]    fp_rd, fp_wr, fp_wait, fp_grant;
    logic [NF*DW-1:0] fp_wd;
    logic [DW-1:0]    fp_rdata, fp_s_wd, fp_s_rdata;
    logic [1:0]       fp_resp, fp_s_resp;
    logic [AW-1:0]    fp_s_addr;
    logic [BW-1:0]    fp_s_be;
    logic             fp_s_rd, fp_s_wr, fp_s_wait, fp_busy;

    // Round-robin instance
    logic [NR*AW-1:0] rr_addr;
    logic [NR*BW-1:0] rr_be;
    logic [NR-1:0]    rr_rd, rr_wr, rr_wait, rr_grant;
    logic [NR*DW-1:0] rr_wd;
    logic [DW-1:0]    rr_rdata, rr_s_wd, rr_s_rdata;
    logic [1:0]       rr_resp, rr_s_resp;
    logic [AW-1:0]    rr_s_addr;
    logic [BW-1:0]    rr_s_be;
    logic             rr_s_rd, rr_s_wr, rr_s_wait, rr_busy;

    mips_avalon_arbiter #(.NUM_MASTERS(NF), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0),
                          .TIMEOUT_CYCLES(TO)) u_fp (
        .clk(clk), .reset(reset),
        .m_address(fp_addr), .m_byteenable(fp_be), .m_read(fp_rd), .m_write(fp_wr),
        .m_writedata(fp_wd), .m_waitrequest(fp_wait), .m_readdata(fp_rdata),
        .m_response(fp_resp), .s_address(fp_s_addr), .s_byteenable(fp_s_be),
        .s_read(fp_s_rd), .s_write(fp_s_wr), .s_writedata(fp_s_wd),
        .s_waitrequest(fp_s_wait), .s_readdata(fp_s_rdata), .s_response(fp_s_resp),
        .grant(fp_grant), .busy(fp_busy)
    );

    mips_avalon_arbiter #(.NUM_MASTERS(NR), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1),
                          .TIMEOUT_CYCLES(TO)) u_rr (
        .clk(clk), .reset(reset),
        .m_address(rr_addr), .m_byteenable(rr_be), .m_read(rr_rd), .m_write(rr_wr),
        .m_writedata(rr_wd), .m_waitrequest(rr_wait), .m_readdata(rr_rdata),
        .m_response(rr_resp), .s_address(rr_s_addr), .s_byteenable(rr_s_be),
        .s_read(rr_s_rd), .s_write(rr_s_wr), .s_writedata(rr_s_wd),
        .s_waitrequest(rr_s_wait), .s_readdata(rr_s_rdata), .s_response(rr_s_resp),
        .grant(rr_grant), .busy(rr_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] rd;
        logic [2:0] wr;
        logic       sw;
        logic [2:0] grant;
        logic       busy;
        logic [2:0] mwait;
        logic       srd;
        logic       swr;
    } vec_t;

    vec_t vt [11];

    initial begin
        int        nzero;
        int        seen;
        int        ngr;
        logic [3:0] rr_seq [5];
        logic [3:0] rr_exp [5];

        // Fixed-priority cycle table: inputs driven at negedge, outputs checked 1 ns later.
        vt[0]  = '{3'b110, 3'b000, 1'b1, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};
        vt[1]  = '{3'b110, 3'b000, 1'b1, 3'b010, 1'b1, 3'b111, 1'b1, 1'b0};
        vt[2]  = '{3'b110, 3'b000, 1'b0, 3'b010, 1'b1, 3'b101, 1'b1, 1'b0};
        vt[3]  = '{3'b100, 3'b000, 1'b1, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};
        vt[4]  = '{3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 3'b011, 1'b1, 1'b0};
        vt[5]  = '{3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};
        vt[6]  = '{3'b000, 3'b000, 1'b1, 3'b001, 1'b1, 3'b111, 1'b0, 1'b0};
        vt[7]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};
        vt[8]  = '{3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};
        vt[9]  = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 3'b110, 1'b1, 1'b0};
        vt[10] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 3'b111, 1'b0, 1'b0};

        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        reset = 1'b0;
        fp_addr = '0; fp_be = '0; fp_rd = '0; fp_wr = '0; fp_wd = '0;
        fp_s_wait = 1'b1; fp_s_rdata = '0; fp_s_resp = '0;
        rr_addr = '0; rr_be = '0; rr_rd = '0; rr_wr = '0; rr_wd = '0;
        rr_s_wait = 1'b0; rr_s_rdata = '0; rr_s_resp = '0;

        // Reset values
        #2;
        chk("rst_grant", 64'(fp_grant), 64'd0);
        chk("rst_busy", 64'(fp_busy), 64'd0);
        chk("rst_mwait", 64'(fp_wait), 64'h7);
        chk("rst_s_read", 64'(fp_s_rd), 64'd0);
        chk("rst_s_addr", 64'(fp_s_addr), 64'd0);
        chk("rst_rr_mwait", 64'(rr_wait), 64'hF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven fixed priority, abort and read-wins sequence
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            fp_rd = vt[i].rd; fp_wr = vt[i].wr; fp_s_wait = vt[i].sw;
            #1;
            chk($sformatf("vec%0d_grant", i), 64'(fp_grant), 64'(vt[i].grant));
            chk($sformatf("vec%0d_busy", i), 64'(fp_busy), 64'(vt[i].busy));
            chk($sformatf("vec%0d_mwait", i), 64'(fp_wait), 64'(vt[i].mwait));
            chk($sformatf("vec%0d_s_read", i), 64'(fp_s_rd), 64'(vt[i].srd));
            chk($sformatf("vec%0d_s_write", i), 64'(fp_s_wr), 64'(vt[i].swr));
        end

        // Single-master read with 2 wait cycles
        @(negedge clk);
        fp_rd = 3'b001; fp_wr = '0; fp_addr[0 +: AW] = 32'hBFC00000; fp_s_wait = 1'b1;
        nzero = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            fp_s_wait  = (n < 2);
            fp_s_rdata = (n < 2) ? 32'h0 : 32'h24020005;
            #1;
            if (fp_wait[0] == 1'b0) nzero++;
            chk($sformatf("rd_grant%0d", n), 64'(fp_grant), 64'h1);
            chk($sformatf("rd_s_addr%0d", n), 64'(fp_s_addr), 64'hBFC00000);
            if (n == 2) chk("rd_rdata", 64'(fp_rdata), 64'h24020005);
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            fp_rd = '0; fp_s_wait = 1'b1;
            #1;
            if (fp_wait[0] == 1'b0) nzero++;
            chk($sformatf("rd_after_busy%0d", n), 64'(fp_busy), 64'd0);
        end
        chk("rd_wait_low_cycles", 64'(nzero), 64'd1);

        // Write pass-through from master 1
        @(negedge clk);
        fp_wr = 3'b010; fp_addr[AW +: AW] = 32'h00001000; fp_wd[DW +: DW] = 32'hDEADBEEF;
        fp_be[BW +: BW] = 4'b0011; fp_s_wait = 1'b0;
        #1;
        chk("wr_idle_s_write", 64'(fp_s_wr), 64'd0);
        @(negedge clk);
        #1;
        chk("wr_s_write", 64'(fp_s_wr), 64'd1);
        chk("wr_s_read", 64'(fp_s_rd), 64'd0);
        chk("wr_s_addr", 64'(fp_s_addr), 64'h1000);
        chk("wr_s_wdata", 64'(fp_s_wd), 64'hDEADBEEF);
        chk("wr_s_be", 64'(fp_s_be), 64'h3);
        chk("wr_mwait", 64'(fp_wait), 64'h5);
        @(negedge clk);
        fp_wr = '0;
        #1;
        chk("wr_done_s_write", 64'(fp_s_wr), 64'd0);
        chk("wr_done_busy", 64'(fp_busy), 64'd0);

        // Round-robin with all four masters requesting continuously
        @(negedge clk);
        rr_rd = 4'hF; rr_s_wait = 1'b0;
        ngr = 0;
        for (int n = 0; n < 30 && ngr < 5; n++) begin
            @(negedge clk);
            #1;
            if (rr_busy) begin
                rr_seq[ngr] = rr_grant;
                ngr++;
            end
        end
        chk("rr_grant_count", 64'(ngr), 64'd5);
        for (int i = 0; i < ngr; i++)
            chk($sformatf("rr_grant%0d", i), 64'(rr_seq[i]), 64'(rr_exp[i]));
        @(negedge clk);
        rr_rd = '0;

        // Reset asserted mid-BUSY
        @(negedge clk);
        fp_rd = 3'b001; fp_s_wait = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_pre_busy", 64'(fp_busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_s_read", 64'(fp_s_rd), 64'd0);
        chk("rstmid_grant", 64'(fp_grant), 64'd0);
        chk("rstmid_mwait", 64'(fp_wait), 64'h7);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fp_s_wait = 1'b0;
        #1;
        chk("rstmid_regrant", 64'(fp_grant), 64'h1);
        chk("rstmid_regrant_s_read", 64'(fp_s_rd), 64'd1);
        @(negedge clk);
        fp_rd = '0; fp_s_wait = 1'b1;

        // Slave stuck in waitrequest
        @(negedge clk);
        fp_rd = 3'b100; fp_s_wait = 1'b1;
`ifdef MIPS_ARB_TIMEOUT_EN
        seen = 0;
        for (int n = 1; n <= 60 && seen == 0; n++) begin
            @(negedge clk);
            #1;
            if (fp_wait[2] == 1'b0) begin
                seen = n;
                chk("tout_resp", 64'(fp_resp), 64'h2);
                chk("tout_rdata", 64'(fp_rdata), 64'd0);
                chk("tout_s_read", 64'(fp_s_rd), 64'd0);
                fp_rd = '0;
            end
        end
        chk("tout_cycle", 64'(seen), 64'(TO + 1));
        @(negedge clk);
        #1;
        chk("tout_then_idle_busy", 64'(fp_busy), 64'd0);
        chk("tout_then_idle_mwait", 64'(fp_wait), 64'h7);
`else
        seen = 0;
        repeat (100) @(negedge clk);
        #1;
        chk("nto_busy", 64'(fp_busy), 64'd1);
        chk("nto_grant", 64'(fp_grant), 64'h4);
        chk("nto_mwait", 64'(fp_wait), 64'h7);
        chk("nto_s_read", 64'(fp_s_rd), 64'd1);
        @(negedge clk);
        fp_s_wait = 1'b0;
        @(negedge clk);
        fp_rd = '0;
        #1;
        chk("nto_done_busy", 64'(fp_busy), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
